// File: rtl/uart_tx_fsm.sv
// UART serial transmitter: start bit, DATA_BITS data bits (LSB first), optional parity,
// STOP_BITS stop bits. Bit timing is taken from the shared OVERSAMPLE x baud sampling strobe.
module uart_tx_fsm #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sampling,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_tx_d,
    output logic                 o_tx_d,
    output logic                 o_tx_busy,
    output logic                 o_tx_done
);

    localparam int             SW        = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [SW-1:0]  SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]     BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [1:0]     STOP_LAST = 2'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t               state;
    logic [SW-1:0]        sample_cnt;
    logic [3:0]           bit_cnt;
    logic [1:0]           stop_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 parity;
    logic                 bit_end;

    assign bit_end = sampling && (sample_cnt == SAMP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= '0;
            shift      <= '0;
            parity     <= 1'b0;
            o_tx_d     <= 1'b1;
            o_tx_busy  <= 1'b0;
            o_tx_done  <= 1'b0;
        end else begin
            o_tx_done <= 1'b0;
            // Shared bit-period counter; IDLE and DONE override it back to zero below.
            if (sampling)
                sample_cnt <= bit_end ? '0 : sample_cnt + 1'b1;

            case (state)
                IDLE: begin
                    o_tx_d     <= 1'b1;
                    o_tx_busy  <= 1'b0;
                    sample_cnt <= '0;
                    if (i_tx_start) begin
                        shift     <= i_tx_d;
                        parity    <= (^i_tx_d) ^ (PARITY_ODD != 0);
                        state     <= START;
                        o_tx_d    <= 1'b0;
                        o_tx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state  <= DATA;
                        o_tx_d <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift <= shift >> 1;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                state  <= PARITY;
                                o_tx_d <= parity;
                            end else begin
                                state  <= STOP;
                                o_tx_d <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            o_tx_d  <= shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state  <= STOP;
                        o_tx_d <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (stop_cnt == STOP_LAST) begin
                            stop_cnt  <= '0;
                            state     <= DONE;
                            o_tx_done <= 1'b1;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    o_tx_busy  <= 1'b0;
                    sample_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm: three configurations, a line-decoding monitor that
// pops expected frames from per-instance scoreboards, a vector table and corner sequences.
module tb_uart_tx_fsm;

    localparam int OS = 16;
    localparam int DB [3] = '{8, 8, 7};
    localparam int PE [3] = '{0, 1, 1};
    localparam int PO [3] = '{0, 0, 1};
    localparam int SB [3] = '{1, 2, 1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sampling = 1'b0;
    logic       start [3];
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic       tx_d [3];
    logic       busy [3];
    logic       done [3];

    uart_tx_fsm #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .sampling(sampling), .i_tx_start(start[0]), .i_tx_d(d0),
        .o_tx_d(tx_d[0]), .o_tx_busy(busy[0]), .o_tx_done(done[0]));
    uart_tx_fsm #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .sampling(sampling), .i_tx_start(start[1]), .i_tx_d(d1),
        .o_tx_d(tx_d[1]), .o_tx_busy(busy[1]), .o_tx_done(done[1]));
    uart_tx_fsm #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .sampling(sampling), .i_tx_start(start[2]), .i_tx_d(d2),
        .o_tx_d(tx_d[2]), .o_tx_busy(busy[2]), .o_tx_done(done[2]));

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Strobe generator: one pulse every samp_div clocks, changed just after the active edge.
    int samp_div = 2;
    int sc = 0;
    initial forever begin
        @(posedge clk);
        #1;
        sc = (sc + 1 >= samp_div) ? 0 : sc + 1;
        sampling = (sc == 0);
    end

    logic [11:0] q0 [$];
    logic [11:0] q1 [$];
    logic [11:0] q2 [$];

    task automatic push_exp(input int i, input logic [11:0] f);
        case (i)
            0: q0.push_back(f);
            1: q1.push_back(f);
            default: q2.push_back(f);
        endcase
    endtask

    task automatic pop_exp(input int i, output logic [11:0] f, output bit ok);
        ok = 1'b0;
        f  = '0;
        case (i)
            0: if (q0.size() > 0) begin f = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin f = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin f = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Reference frame, bit k = line value during bit period k.
    function automatic logic [11:0] model_frame(input int i, input logic [7:0] b);
        logic [11:0] f;
        int k;
        int ones;
        f = '0; k = 1; ones = 0;
        for (int j = 0; j < DB[i]; j++) begin
            f[k] = b[j];
            if (b[j]) ones++;
            k++;
        end
        if (PE[i] != 0) begin
            f[k] = ((ones % 2) == 1) ^ (PO[i] != 0);
            k++;
        end
        for (int j = 0; j < SB[i]; j++) begin
            f[k] = 1'b1;
            k++;
        end
        return f;
    endfunction

    // Monitor: decodes each frame by counting strobes, checks bit stability and done timing.
    int          st [3]        = '{0, 0, 0};
    int          pcnt [3]      = '{0, 0, 0};
    int          bidx [3]      = '{0, 0, 0};
    int          frames [3]    = '{0, 0, 0};
    int          rise_cyc [3]  = '{0, 0, 0};
    int          done_cyc [3]  = '{0, 0, 0};
    logic        cur [3];
    logic        prev_busy [3];
    logic [11:0] fr [3];
    int          cyc = 0;

    initial begin
        for (int i = 0; i < 3; i++) begin prev_busy[i] = 1'b0; cur[i] = 1'b1; fr[i] = '0; end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    st[i] = 0;
                    prev_busy[i] = 1'b0;
                end else begin
                    case (st[i])
                        0: if (busy[i] && !prev_busy[i]) begin
                               chk("start_bit", {31'd0, tx_d[i]}, 0);
                               st[i] = 1; pcnt[i] = 0; bidx[i] = 0; fr[i] = '0;
                               rise_cyc[i] = cyc;
                           end else begin
                               chk("idle_line", {29'd0, tx_d[i], busy[i], done[i]}, 3'b100);
                           end
                        2: begin
                               logic [11:0] e;
                               bit ok;
                               chk("done_pulse", {29'd0, tx_d[i], busy[i], done[i]}, 3'b111);
                               pop_exp(i, e, ok);
                               if (!ok) chk("unexpected_frame", {20'd0, fr[i]}, 32'hFFFF_FFFF);
                               else     chk("frame", {20'd0, fr[i]}, {20'd0, e});
                               frames[i]++;
                               done_cyc[i] = cyc;
                               st[i] = 3;
                           end
                        3: begin
                               chk("post_done", {29'd0, tx_d[i], busy[i], done[i]}, 3'b100);
                               st[i] = 0;
                           end
                        default: ;
                    endcase
                    if (st[i] == 1 && sampling) begin
                        pcnt[i]++;
                        if (pcnt[i] == 1) begin
                            cur[i] = tx_d[i];
                            fr[i][bidx[i]] = tx_d[i];
                        end
                        chk("bit_hold", {29'd0, tx_d[i], busy[i], done[i]}, {29'd0, cur[i], 2'b10});
                        if (pcnt[i] == OS) begin
                            pcnt[i] = 0;
                            bidx[i]++;
                            if (bidx[i] == 1 + DB[i] + PE[i] + SB[i]) st[i] = 2;
                        end
                    end
                    prev_busy[i] = busy[i];
                end
            end
        end
    end

    task automatic set_data(input int i, input logic [7:0] b);
        case (i)
            0: d0 = b;
            1: d1 = b;
            default: d2 = b[6:0];
        endcase
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        @(negedge clk);
        while (busy[i] && n < 4000) begin @(negedge clk); n++; end
        chk("wait_idle", {31'd0, busy[i]}, 0);
    endtask

    task automatic send(input int i, input logic [7:0] b, input logic [11:0] f);
        wait_idle(i);
        @(posedge clk); #1;
        set_data(i, b);
        start[i] = 1'b1;
        push_exp(i, f);
        @(posedge clk); #1;
        start[i] = 1'b0;
        set_data(i, ~b);
    endtask

    task automatic wait_frames(input int i, input int tgt);
        int n;
        n = 0;
        while (frames[i] < tgt && n < 20000) begin @(negedge clk); n++; end
        chk("frame_wait", {31'd0, frames[i] >= tgt}, 1);
    endtask

    typedef struct {
        int          inst;
        logic [7:0]  data;
        int          div;
        logic [11:0] frame;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int f0;
        int n;
        logic [7:0] b;

        tbl[0] = '{0, 8'hA5, 2, 12'h34A};
        tbl[1] = '{1, 8'h07, 1, 12'hE0E};
        tbl[2] = '{2, 8'h07, 3, 12'h20E};
        tbl[3] = '{0, 8'h00, 1, 12'h200};
        tbl[4] = '{0, 8'hFF, 3, 12'h3FE};
        tbl[5] = '{1, 8'h00, 2, 12'hC00};
        tbl[6] = '{2, 8'h55, 1, 12'h3AA};

        for (int i = 0; i < 3; i++) start[i] = 1'b0;
        d0 = '0; d1 = '0; d2 = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            chk("reset_state", {29'd0, tx_d[i], busy[i], done[i]}, 3'b100);
        @(posedge clk); #2;
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            samp_div = tbl[k].div;
            f0 = frames[tbl[k].inst];
            send(tbl[k].inst, tbl[k].data, tbl[k].frame);
            wait_frames(tbl[k].inst, f0 + 1);
        end

        // Start request mid-frame must be dropped.
        samp_div = 2;
        f0 = frames[0];
        send(0, 8'h3C, model_frame(0, 8'h3C));
        repeat (100) @(posedge clk);
        #1; d0 = 8'hFF; start[0] = 1'b1;
        @(posedge clk); #1; start[0] = 1'b0;
        wait_frames(0, f0 + 1);
        repeat (400) @(posedge clk);
        #1;
        chk("midframe_one_done", frames[0], f0 + 1);
        chk("midframe_idle", {31'd0, busy[0]}, 0);

        // Reset during data bit 3 aborts the frame at once.
        samp_div = 1;
        f0 = frames[0];
        send(0, 8'h96, model_frame(0, 8'h96));
        n = 0;
        while (!(st[0] == 1 && bidx[0] == 4 && pcnt[0] >= 5) && n < 2000) begin @(negedge clk); n++; end
        chk("reach_bit3", bidx[0], 4);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_abort", {29'd0, tx_d[0], busy[0], done[0]}, 3'b100);
        q0.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        send(0, 8'h5A, model_frame(0, 8'h5A));
        wait_frames(0, f0 + 1);

        // Start held high: back-to-back frames.
        wait_idle(0);
        f0 = frames[0];
        @(posedge clk); #1;
        d0 = 8'h00; start[0] = 1'b1;
        push_exp(0, model_frame(0, 8'h00));
        push_exp(0, model_frame(0, 8'hFF));
        n = 0;
        @(negedge clk);
        while (!busy[0] && n < 100) begin @(negedge clk); n++; end
        d0 = 8'hFF;
        wait_frames(0, f0 + 1);
        n = 0;
        while (rise_cyc[0] <= done_cyc[0] && n < 100) begin @(negedge clk); n++; end
        chk("b2b_gap", rise_cyc[0] - done_cyc[0], 2);
        @(posedge clk); #1; start[0] = 1'b0;
        wait_frames(0, f0 + 2);

        // Random traffic through the decoding monitor.
        samp_div = 1;
        f0 = frames[1];
        for (int k = 0; k < 48; k++) begin
            b = 8'($urandom);
            send(1, b, model_frame(1, b));
        end
        wait_frames(1, f0 + 48);
        f0 = frames[2];
        for (int k = 0; k < 24; k++) begin
            b = 8'($urandom_range(0, 127));
            send(2, b, model_frame(2, b));
        end
        wait_frames(2, f0 + 24);

        repeat (20) @(posedge clk);
        #1;
        chk("queues_empty", q0.size() + q1.size() + q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
